run_length_logger: RTL and testbench
====================================

Name: run_length_logger

Overview:
- Downstream of the serial pattern-detector stage. Consumes that stage's 1-bit output stream `q` on the `bit_in` port.
- Measures the length of every run of consecutive 1s, one sample per clock.
- Queues each completed run length in a small FIFO and presents it on a valid/ready interface to the host or monitor logic.
- Example: a detector output of 00000000011110011000000001100000 yields records 4, 2, 2.

Parameters:
- LEN_W, default 8: width of the run-length field. Maximum recordable length is 2^LEN_W-1.
- DEPTH, default 4: number of FIFO entries. Must be a power of 2, at least 2.
- CNT_W, default 3: width of `fifo_count`. Must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low. reset=0 clears all state immediately.
- bit_in  input  1  serial bit from the detector stage, sampled every rising edge.
- clear  input  1  synchronous clear: empties the FIFO, zeroes the run counter, clears `overflow`.
- out_valid  output  1  FIFO holds at least one record.
- out_ready  input  1  consumer accepts the head record this cycle.
- out_len  output  LEN_W  run length of the head record.
- out_sat  output  1  head record's run was saturated at the maximum.
- fifo_count  output  CNT_W  number of records held, 0..DEPTH.
- overflow  output  1  sticky: set when a record is dropped because the FIFO is full.

Behaviour:
- Reset (reset=0, asynchronous): run_cnt=0, sat_flag=0, FIFO empty, out_valid=0, out_len=0, out_sat=0, fifo_count=0, overflow=0. A run in progress is discarded.
- Run counter, evaluated at each rising edge:
  - bit_in=1 and run_cnt<MAX: run_cnt increments by 1.
  - bit_in=1 and run_cnt=MAX: run_cnt holds at MAX and sat_flag is set.
  - bit_in=0 and run_cnt>0: push record {sat_flag, run_cnt}, then run_cnt=0 and sat_flag=0.
  - bit_in=0 and run_cnt=0: no action.
- Latency: the record is visible on out_valid/out_len/out_sat immediately after the edge that samples the terminating 0. The FIFO is first-word-fall-through.
- A run still open when the stream stops produces no record until a 0 is sampled.
- Pop: occurs on the edge where out_valid=1 and out_ready=1. out_ready while empty is ignored.
- Head outputs: out_len and out_sat show the head entry when out_valid=1. When empty they hold 0.
- Push while full without a simultaneous pop: record dropped, overflow set to 1, FIFO unchanged.
- Push and pop in the same cycle:
  - Always accepted, including when full; fifo_count is unchanged.
  - When fifo_count=1, the new record becomes the head after the edge.
- clear=1 at an edge:
  - Overrides push and pop: FIFO emptied, run_cnt=0, sat_flag=0, overflow=0.
  - bit_in on that edge is ignored.
- overflow is cleared only by reset or clear.
- FIFO pointers: log2(DEPTH) bits, wrapping naturally. fifo_count is maintained separately and derives full (DEPTH) and empty (0).
- Run lengths are unsigned. A single-cycle 1 gives length 1. No record of length 0 is ever produced.

Decomposition:
- Shared package/constants file: LEN_W default and a record width constant, REC_W = LEN_W+1.
- Shared record layout: bit LEN_W = sat, bits LEN_W-1:0 = len.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH).
  - Ports: clk, reset, clear, push, din, pop, dout, count, full, empty.
  - Reused by other stages.
- The top contains only the run counter, push generation, and overflow/handshake glue.

Test Plan:
- Detector stream: feed 00000000011110011000000001100000 with out_ready=1 -> three records: len 4, 2, 2, all sat=0; overflow=0. Each out_valid pulse follows the edge sampling the terminating 0.
- Backpressure and overflow, DEPTH=4, out_ready=0: feed runs 1,2,3,4,5 (each followed by a 0) -> fifo_count=4, fifo_count never exceeds 4, overflow=1. Then raise out_ready -> records pop in order 1,2,3,4.
- Saturation, LEN_W=4: hold bit_in=1 for 20 cycles then 0 -> one record, len=15, sat=1. A following run of 3 -> len=3, sat=0.
- Full with simultaneous push/pop: fill to 4, then on the edge a new run ends assert out_ready=1 -> fifo_count stays 4, overflow stays 0, new record is last.
- Reset mid-run: bit_in=1 for 3 cycles, assert reset low asynchronously mid-cycle -> outputs zero immediately. After release, feed 0 then run of 2 -> only len 2 recorded.
- clear: with 2 records queued and overflow=1, pulse clear for one edge -> fifo_count=0, out_valid=0, overflow=0, and bit_in on that edge is ignored.

Source files
------------

// File: rtl/run_length_logger_pkg.sv
// Shared constants and record helpers for the run-length logging stage.
package run_length_logger_pkg;

    // Default run-length field width and the record width derived from it.
    localparam int DEF_LEN_W = 8;
    localparam int DEF_REC_W = DEF_LEN_W + 1;

    // Default FIFO geometry.
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 3;

    // Record layout: bit LEN_W carries the saturation flag, bits LEN_W-1:0 the length.
    function automatic int rec_width(input int len_w);
        return len_w + 1;
    endfunction

    // Width of an occupancy counter able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with separate occupancy count.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == CNT_W'(DEPTH));
    assign count = count_r;
    // Head data is forced to zero while empty so stale entries never leak out.
    assign dout  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Qualify requests: pops need data, pushes need room unless a pop frees a slot.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && (!full || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Storage write; clear only needs to reset pointers, not the data.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; clear has priority over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/run_length_logger.sv
// Measures runs of consecutive 1s on the detector stream and queues their lengths.
module run_length_logger
    import run_length_logger_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] out_len,
    output logic             out_sat,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    localparam int              REC_W   = rec_width(LEN_W);
    localparam logic [LEN_W-1:0] MAX_LEN = {LEN_W{1'b1}};

    logic [LEN_W-1:0] run_cnt_r;
    logic             sat_flag_r;
    logic             overflow_r;
    logic             push_s;
    logic [REC_W-1:0] rec_s;
    logic [REC_W-1:0] head_s;
    logic             full_s;
    logic             empty_s;

    // A record is due when a 0 terminates a non-empty run.
    assign push_s = !bit_in && (run_cnt_r != {LEN_W{1'b0}});
    assign rec_s  = {sat_flag_r, run_cnt_r};

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push_s),
        .din   (rec_s),
        .pop   (out_ready),
        .dout  (head_s),
        .count (fifo_count),
        .full  (full_s),
        .empty (empty_s)
    );

    assign out_valid = !empty_s;
    assign out_len   = head_s[LEN_W-1:0];
    assign out_sat   = head_s[LEN_W];
    assign overflow  = overflow_r;

    // Run counter: count 1s, saturate at the field maximum, restart after a 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt_r  <= {LEN_W{1'b0}};
            sat_flag_r <= 1'b0;
        end else if (clear) begin
            run_cnt_r  <= {LEN_W{1'b0}};
            sat_flag_r <= 1'b0;
        end else if (bit_in) begin
            if (run_cnt_r != MAX_LEN) begin
                run_cnt_r <= run_cnt_r + LEN_W'(1);
            end else begin
                sat_flag_r <= 1'b1;
            end
        end else begin
            run_cnt_r  <= {LEN_W{1'b0}};
            sat_flag_r <= 1'b0;
        end
    end

    // Sticky drop indicator: a push into a full FIFO with no pop loses the record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (clear) begin
            overflow_r <= 1'b0;
        end else if (push_s && full_s && !out_ready) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

endmodule

// File: tb/tb_run_length_logger.sv
// Scoreboard bench: a stream-level model predicts records, a monitor checks the DUT.
module tb_run_length_logger;

    localparam int LEN_W = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int MAXL  = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             bit_in;
    logic             clear;
    logic             out_ready;
    logic             out_valid;
    logic [LEN_W-1:0] out_len;
    logic             out_sat;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    run_length_logger #(
        .LEN_W (LEN_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_len    (out_len),
        .out_sat    (out_sat),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int sat;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rec = 0;
    int   m_run = 0;
    int   m_occ = 0;
    int   m_ovf = 0;
    bit   m_pop;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run lengths as plain integers, FIFO as an occupancy count.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset || clear) begin
                m_run = 0;
                m_occ = 0;
                m_ovf = 0;
                exp_q.delete();
            end else begin
                m_pop = out_ready && (m_occ > 0);
                if (m_pop) m_occ--;
                if (bit_in) begin
                    m_run++;
                end else if (m_run > 0) begin
                    if (m_occ < DEPTH) begin
                        rec_t r;
                        r.len = (m_run > MAXL) ? MAXL : m_run;
                        r.sat = (m_run > MAXL) ? 1 : 0;
                        exp_q.push_back(r);
                        m_occ++;
                    end else begin
                        m_ovf = 1;
                    end
                    m_run = 0;
                end
            end
        end
    end

    // Monitor: status checks every cycle, record comparison on each handshake.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            chk("fifo_count", int'(fifo_count), m_occ);
            chk("out_valid", int'(out_valid), int'(m_occ > 0));
            chk("overflow", int'(overflow), m_ovf);
            if (!out_valid) begin
                chk("empty_len", int'(out_len), 0);
                chk("empty_sat", int'(out_sat), 0);
            end
            if (reset && !clear && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", int'(out_len), -1);
                end else begin
                    r = exp_q.pop_front();
                    chk("rec_len", int'(out_len), r.len);
                    chk("rec_sat", int'(out_sat), r.sat);
                    n_rec++;
                end
            end
        end
    end

    task automatic cyc(input bit b, input bit r, input bit c);
        bit_in    = b;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit r);
        repeat (n) cyc(1'b1, r, 1'b0);
        cyc(1'b0, r, 1'b0);
    endtask

    string stream;
    int    rec_base;
    int    p_one;
    int    p_rdy;

    initial begin
        reset     = 1'b0;
        bit_in    = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_ovf", int'(overflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Detector stream example: records 4, 2, 2.
        stream   = "00000000011110011000000001100000";
        rec_base = n_rec;
        for (int i = 0; i < stream.len(); i++) cyc(stream[i] == 8'h31, 1'b1, 1'b0);
        chk("stream_records", n_rec - rec_base, 3);
        chk("stream_drained", exp_q.size(), 0);

        // Backpressure and overflow: runs 1..5 with out_ready low, then drain 1..4.
        for (int k = 1; k <= 5; k++) run(k, 1'b0);
        chk("bp_count", int'(fifo_count), 4);
        chk("bp_ovf", int'(overflow), 1);
        rec_base = n_rec;
        repeat (6) cyc(1'b0, 1'b1, 1'b0);
        chk("bp_records", n_rec - rec_base, 4);

        // Clear with two records queued and overflow set; bit_in on that edge ignored.
        for (int k = 1; k <= 5; k++) run(k, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        chk("preclr_count", int'(fifo_count), 2);
        cyc(1'b1, 1'b0, 1'b1);
        chk("clr_count", int'(fifo_count), 0);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_valid", int'(out_valid), 0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        chk("clr_no_record", int'(fifo_count), 0);

        // Saturation: 20 ones then a run of 3.
        run(20, 1'b1);
        run(3, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);

        // Full FIFO with simultaneous push and pop.
        for (int k = 0; k < 4; k++) run(1, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("pp_count", int'(fifo_count), 4);
        chk("pp_ovf", int'(overflow), 0);
        repeat (6) cyc(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-run with a record queued.
        run(2, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_count", int'(fifo_count), 0);
        chk("arst_len", int'(out_len), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        rec_base = n_rec;
        run(2, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("arst_records", n_rec - rec_base, 1);

        // Randomized traffic with varying run density and backpressure.
        for (int blk = 0; blk < 20; blk++) begin
            p_one = $urandom_range(30, 97);
            p_rdy = $urandom_range(10, 100);
            for (int i = 0; i < 150; i++) begin
                cyc($urandom_range(0, 99) < p_one,
                    $urandom_range(0, 99) < p_rdy,
                    $urandom_range(0, 299) == 0);
            end
        end
        repeat (8) cyc(1'b0, 1'b1, 1'b0);
        chk("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
